decoder_rr_arbiter: RTL
=======================

# decoder_rr_arbiter

Round-robin arbiter sharing one decoded resource among four requesters. It sequences a 2-to-4 decoder's enable/select lines (G, S1, S0) and presents the decoded one-hot grant. Each grant lasts until its requester drops its request or a hold limit expires, and a one-cycle dead gap separates consecutive grants. It sits between requesting units and the decoder that selects the shared resource.

## Interface
- MAX_HOLD, 8, maximum consecutive grant cycles per owner before forced release; legal range 1..15
- CNT_W, 4, hold counter width; must satisfy 2^CNT_W > MAX_HOLD
- clk  input  1  system clock, rising edge active
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  request lines; req[i] high = requester i wants the resource
- gnt  output  4  one-hot grant; all zero when no grant is held
- G  output  1  decoder enable; high only while a grant is held
- S1  output  1  decoder select MSB; equals owner[1]
- S0  output  1  decoder select LSB; equals owner[0]
- owner  output  2  index of current or most recent grantee
- busy  output  1  high while in BUSY
- preempt  output  1  one-cycle pulse in GAP after a forced release

## Operation
- States: IDLE, BUSY, GAP. All outputs are registered or decoded from registered state only.
- Internal registers: rotating priority pointer ptr[1:0] and hold counter hold_cnt[CNT_W-1:0].
- Selection: with any req bit set, the winner is the first i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
- IDLE:
  - If any req is set, go to BUSY, owner <= winner, hold_cnt <= 1.
  - Otherwise stay in IDLE.
- BUSY:
  - If req[owner]=0, this is a normal release: go to GAP.
  - Else if hold_cnt==MAX_HOLD, this is a forced release: go to GAP and set preempt for the GAP cycle.
  - Else stay in BUSY and increment hold_cnt.
  - If req[owner] drops on the same edge that hold_cnt==MAX_HOLD, it is a normal release and preempt is not set.
  - On either release, ptr <= owner+1 (mod 4, so 3 wraps to 0).
- GAP:
  - gnt=0 and G=0.
  - If any req is set, go to BUSY with a fresh arbitration using the updated ptr and hold_cnt <= 1.
  - Otherwise go to IDLE.
  - The previous owner may win again only if no other requester is set.
- Decoder drive:
  - G = (state==BUSY).
  - {S1,S0} = owner.
  - gnt = G ? (4'b0001 << owner) : 4'b0000.
  - gnt must equal the 2-to-4 decoder truth table output for (G, S1, S0).
- owner holds its value through GAP and IDLE. Select lines are only meaningful while G=1.
- busy = (state==BUSY).

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE, ptr=0, owner=0, hold_cnt=0.
  - gnt=4'b0000, G=0, S1=0, S0=0, busy=0, preempt=0.
- Reset asserted mid-grant: gnt and G drop without waiting for a clock edge.
- After rst_n deasserts, the first arbitration happens on the first rising edge at which req is nonzero.
- Grant latency: req sampled high at edge k gives gnt visible after edge k, in cycle k+1.
- Release latency: req[owner] sampled low at edge k gives gnt=0 from cycle k+1, which is the GAP cycle.
- Hold time: a continuously requesting owner receives exactly MAX_HOLD cycles of gnt, then one GAP cycle.
- Back-to-back grants: the minimum spacing between the end of one grant and the start of the next is one dead cycle.
- MAX_HOLD=1: every grant lasts one cycle, giving a 1-on/1-off pattern under constant requests.
- req changes from non-owners during BUSY are ignored until the next arbitration.
- Requester rules:
  - A requester must hold req until it sees gnt.
  - Dropping req before the grant is legal; the requester simply loses the arbitration.

## Test plan
- Single requester: req=4'b0100 for 3 cycles, then 0. Expect gnt=4'b0100 for 3 cycles starting one cycle after req, with G=1, S1=1, S0=0. Then one GAP cycle, then IDLE with gnt=0.
- Round-robin with all four: req=4'b1111 held, each owner dropping req after 2 grant cycles and re-raising it. Expect grant order 0,1,2,3,0 with one zero cycle between grants, and ptr wrapping from 3 to 0.
- Forced release: MAX_HOLD=8, req=4'b0011 held constantly. Expect gnt=0001 for exactly 8 cycles, then GAP with preempt=1 and gnt=0, then gnt=0010 for 8 cycles.
- Simultaneous drop at the limit: req[owner] falls on the edge where hold_cnt==MAX_HOLD. Expect GAP with preempt=0.
- Reset mid-grant: pull rst_n low while gnt=4'b1000. Expect gnt=0 and G=0 immediately, with owner=0 and busy=0. After release with req=4'b1010, expect the first grant to go to requester 1 (ptr=0).
- Decoder consistency: across all scenarios, check every cycle that gnt equals the 2-to-4 decode of (G, S1, S0) and that gnt is never multi-hot.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin arbiter with a hold limit and a one-cycle gap between grants, driving a 2-to-4 decoder
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       G,
  output logic       S1,
  output logic       S0,
  output logic [1:0] owner,
  output logic       busy,
  output logic       preempt
);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [CNT_W-1:0] hold_cnt;
  // scan from ptr+3 down to ptr so the last hit is the first in priority order
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE, GAP:
          if (|req) begin
            state    <= BUSY;
            owner    <= win;
            hold_cnt <= CNT_W'(1);
          end else state <= IDLE;
        BUSY:
          // a drop coinciding with the limit counts as a normal release
          if (!req[owner] || hold_cnt == CNT_W'(MAX_HOLD)) begin
            state   <= GAP;
            ptr     <= owner + 2'd1;
            preempt <= req[owner];
          end else hold_cnt <= hold_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
  assign G    = (state == BUSY);
  assign busy = G;
  assign S1   = owner[1];
  assign S0   = owner[0];
  assign gnt  = G ? (4'b0001 << owner) : 4'b0000;
endmodule
